// File: rtl/imm_extend_pipe.sv
// Registered immediate extender for the decode stage. A two-entry skid buffer sits behind a
// valid/ready handshake, and a destination tag travels with each result.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [IN_W-1:0]  In,
  input  logic [1:0]       Mode,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [OUT_W-1:0] Out,
  output logic [TAG_W-1:0] OutTag
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] main_q, main_d, skid_q, skid_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, pop;
  logic [OUT_W-1:0] sext, ext;

  assign accept = InValid & in_ready_q;
  assign pop    = OutValid & OutReady;

  assign sext = {{(OUT_W-IN_W){In[IN_W-1]}}, In};

  // The final result is formed before capture so Out is a straight register output.
  always_comb begin
    ext = '0;
    case (Mode)
      2'b00:   ext = {{(OUT_W-IN_W){1'b0}}, In};
      2'b01:   ext = sext;
      2'b10:   ext = {In, {(OUT_W-IN_W){1'b0}}};
      2'b11:   ext = {sext[OUT_W-3:0], 2'b00};
      default: ext = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_tag_d = main_tag_q;
    skid_d     = skid_q;
    skid_tag_d = skid_tag_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d    = StOne;
          main_d     = ext;
          main_tag_d = InTag;
        end
      end
      StOne: begin
        if (accept && !pop) begin
          state_d    = StTwo;
          skid_d     = ext;
          skid_tag_d = InTag;
        end else if (accept && pop) begin
          main_d     = ext;
          main_tag_d = InTag;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // InReady is low here, so only a pop can happen.
        if (pop) begin
          state_d    = StOne;
          main_d     = skid_q;
          main_tag_d = skid_tag_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      main_tag_q <= '0;
      skid_q     <= '0;
      skid_tag_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      main_tag_q <= main_tag_d;
      skid_q     <= skid_d;
      skid_tag_q <= skid_tag_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = (state_q != StEmpty);
  assign Out      = main_q;
  assign OutTag   = main_tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed vector table, backpressure and reset sequences, and
// random traffic checked against a queue-based reference model.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [1:0]  mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [7:0]  n_in;
  logic [1:0]  n_mode;
  logic [4:0]  n_in_tag, n_out_tag;
  logic [15:0] n_out;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic mon_en   = 1'b0;
  logic last_acc = 1'b0;

  typedef struct {
    logic [31:0] out;
    logic [4:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        narrow;
    logic [15:0] in;
    logic [1:0]  mode;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  imm_extend_pipe u_dut (
    .Clk(clk), .Rst(rst), .InValid(in_valid), .InReady(in_ready), .In(in_data), .Mode(mode),
    .InTag(in_tag), .OutValid(out_valid), .OutReady(out_ready), .Out(out_data), .OutTag(out_tag)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) u_dut8 (
    .Clk(clk), .Rst(rst), .InValid(n_in_valid), .InReady(n_in_ready), .In(n_in),
    .Mode(n_mode), .InTag(n_in_tag), .OutValid(n_out_valid), .OutReady(n_out_ready),
    .Out(n_out), .OutTag(n_out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Extension computed arithmetically: sign value, scaling, then wrap modulo 2^ow.
  function automatic logic [31:0] ref_ext(input logic [31:0] v, input logic [1:0] m,
                                          input int iw, input int ow);
    longint md, sv, r;
    md = longint'(1) << ow;
    sv = longint'(v);
    if (v[iw-1]) sv = sv - (longint'(1) << iw);
    case (m)
      2'd0:    r = longint'(v);
      2'd1:    r = sv;
      2'd2:    r = longint'(v) * (longint'(1) << (ow - iw));
      default: r = sv * 4;
    endcase
    r = ((r % md) + md) % md;
    return 32'(r);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic acc, pp;
    if (rst || !mon_en) begin
      exp_q.delete();
      last_acc = 1'b0;
    end else begin
      acc = in_valid && in_ready;
      pp  = out_valid && out_ready;
      check("mon_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      check("mon_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      if (pp) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_pop: got pop expected no item held");
        end else begin
          e = exp_q.pop_front();
          check("mon_out", 64'(out_data), 64'(e.out));
          check("mon_tag", 64'(out_tag), 64'(e.tag));
          pops++;
        end
      end
      if (acc) begin
        e.out = ref_ext({16'h0, in_data}, mode, 16, 32);
        e.tag = in_tag;
        exp_q.push_back(e);
      end
      last_acc = acc;
    end
  end

  initial begin
    int snap;
    int k;
    vecs[0] = '{1'b0, 16'h8000, 2'b01, 5'd1, 32'hFFFF8000};
    vecs[1] = '{1'b0, 16'h8000, 2'b00, 5'd2, 32'h00008000};
    vecs[2] = '{1'b0, 16'h1234, 2'b10, 5'd3, 32'h12340000};
    vecs[3] = '{1'b0, 16'hFFFF, 2'b11, 5'd4, 32'hFFFFFFFC};
    vecs[4] = '{1'b0, 16'h0004, 2'b11, 5'd5, 32'h00000010};
    vecs[5] = '{1'b1, 16'h0080, 2'b01, 5'd6, 32'h0000FF80};
    vecs[6] = '{1'b1, 16'h005A, 2'b10, 5'd7, 32'h00005A00};
    vecs[7] = '{1'b1, 16'h00C0, 2'b11, 5'd8, 32'h0000FF00};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; mode = '0; in_tag = '0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_in = '0; n_mode = '0; n_in_tag = '0; n_out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out", 64'(out_data), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed vectors, one at a time, latency one.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].narrow) begin
        n_in_valid = 1'b1; n_in = vecs[i].in[7:0]; n_mode = vecs[i].mode;
        n_in_tag = vecs[i].tag;
        step();
        n_in_valid = 1'b0;
        check("vec_n_valid", 64'(n_out_valid), 64'(1));
        check("vec_n_out", 64'(n_out), 64'(vecs[i].exp));
        check("vec_n_tag", 64'(n_out_tag), 64'(vecs[i].tag));
      end else begin
        in_valid = 1'b1; in_data = vecs[i].in; mode = vecs[i].mode; in_tag = vecs[i].tag;
        step();
        in_valid = 1'b0;
        check("vec_valid", 64'(out_valid), 64'(1));
        check("vec_out", 64'(out_data), 64'(vecs[i].exp));
        check("vec_tag", 64'(out_tag), 64'(vecs[i].tag));
      end
      step();
    end

    // Backpressure: A, B, C back to back with the consumer stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0001; mode = 2'b01; in_tag = 5'd1;
    step();
    check("bp_a_valid", 64'(out_valid), 64'(1));
    check("bp_a_ready", 64'(in_ready), 64'(1));
    in_data = 16'h8001; mode = 2'b01; in_tag = 5'd2;
    step();
    check("bp_b_ready", 64'(in_ready), 64'(0));
    check("bp_a_held", 64'(out_data), 64'h1);
    in_data = 16'h7FFF; mode = 2'b10; in_tag = 5'd3;
    step();
    step();
    check("bp_a_stable", 64'(out_data), 64'h1);
    check("bp_a_tag", 64'(out_tag), 64'(1));
    check("bp_stall_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    step();
    check("bp_b_out", 64'(out_data), 64'hFFFF8001);
    check("bp_b_tag", 64'(out_tag), 64'(2));
    check("bp_ready_back", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    check("bp_c_out", 64'(out_data), 64'h7FFF0000);
    check("bp_c_tag", 64'(out_tag), 64'(3));
    step();
    check("bp_empty", 64'(out_valid), 64'(0));

    // Streaming at full rate.
    snap = pops;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom); mode = 2'($urandom); in_tag = 5'($urandom);
      step();
      check("stream_in_ready", 64'(in_ready), 64'(1));
      check("stream_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    step();
    step();
    check("stream_count", 64'(pops - snap), 64'(100));

    // Random handshake toggling; an unaccepted item is held until taken.
    snap = pops;
    for (int i = 0; i < 1000; i++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = 1'($urandom); in_data = 16'($urandom); mode = 2'($urandom);
        in_tag = 5'($urandom);
      end
      out_ready = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      step();
      k++;
    end
    check("rand_drain", 64'(exp_q.size()), 64'(0));
    check("rand_some_pops", 64'(pops - snap > 100), 64'(1));

    // Reset while full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111; mode = 2'b00; in_tag = 5'd9;
    step();
    in_data = 16'h2222; in_tag = 5'd10;
    step();
    check("rst2_full", 64'(in_ready), 64'(0));
    rst = 1'b1;
    in_data = 16'h3333; in_tag = 5'd11;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst2_out_valid", 64'(out_valid), 64'(0));
    check("rst2_in_ready", 64'(in_ready), 64'(1));
    check("rst2_out", 64'(out_data), 64'(0));
    check("rst2_out_tag", 64'(out_tag), 64'(0));
    in_valid = 1'b1; in_data = 16'h00F0; mode = 2'b10; in_tag = 5'd12;
    step();
    in_valid = 1'b0;
    check("rst2_fresh_valid", 64'(out_valid), 64'(1));
    check("rst2_fresh_out", 64'(out_data), 64'h00F00000);
    check("rst2_fresh_tag", 64'(out_tag), 64'(12));
    out_ready = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
